hilo_unit: RTL and testbench

Requester side of the iterative divider handshake and owner of the architectural HI/LO registers in the EXE stage. It accepts one HI/LO-class instruction at a time: DIV, DIVU, MULT, MULTU, MTHI or MTLO. For divides it drives the divider's hold-high request, waits for the one-cycle completion pulse and captures quotient into LO and remainder into HI. It stalls the pipeline while busy and abandons an in-flight operation on flush.

---
 rtl/hilo_pkg.sv | 38 +++
 rtl/hilo_mul.sv | 27 ++
 rtl/hilo_unit.sv | 158 +++++++++++++++
 tb/tb_hilo_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hilo_pkg
// Brief    : Opcodes, state encoding and widths shared by the HI/LO unit.
// Revision : 1.0
// ============================================================================
package hilo_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned DLEN = 64;

    typedef logic [2:0] hilo_op_t;

    localparam hilo_op_t OP_NOP   = 3'd0;
    localparam hilo_op_t OP_DIV   = 3'd1;
    localparam hilo_op_t OP_DIVU  = 3'd2;
    localparam hilo_op_t OP_MULT  = 3'd3;
    localparam hilo_op_t OP_MULTU = 3'd4;
    localparam hilo_op_t OP_MTHI  = 3'd5;
    localparam hilo_op_t OP_MTLO  = 3'd6;

    typedef logic [1:0] hilo_state_t;

    localparam hilo_state_t ST_IDLE    = 2'd0;
    localparam hilo_state_t ST_DIV_RUN = 2'd1;
    localparam hilo_state_t ST_MUL_RUN = 2'd2;
    localparam hilo_state_t ST_DONE    = 2'd3;

    function automatic logic op_is_div(input hilo_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_mul(input hilo_op_t op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_mul.sv
`default_nettype none
// ============================================================================
// Module   : hilo_mul
// Brief    : 33x33 signed multiplier (operands sign/zero-extended by signed_i),
//            64-bit product.
// Revision : 1.0
// ============================================================================
module hilo_mul
    import hilo_pkg::*;
(
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            signed_i,
    output logic [DLEN-1:0] prod_o
);

    logic [DLEN-1:0] w_a_ext;
    logic [DLEN-1:0] w_b_ext;

    // Extending straight to 64 bits keeps the low half of the product identical
    // to the 33x33 result, so one unsigned multiply covers both flavours.
    assign w_a_ext = {{(DLEN - XLEN){signed_i & a_i[XLEN-1]}}, a_i};
    assign w_b_ext = {{(DLEN - XLEN){signed_i & b_i[XLEN-1]}}, b_i};
    assign prod_o  = w_a_ext * w_b_ext;

endmodule
`default_nettype wire

// File: rtl/hilo_unit.sv
`default_nettype none
// ============================================================================
// Module   : hilo_unit
// Brief    : HI/LO register owner and requester side of the iterative divider
//            handshake. Multiplier is present only when HILO_MUL_EN is defined.
// Revision : 1.0
// ============================================================================
module hilo_unit
    import hilo_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_src1,
    input  logic [XLEN-1:0] req_src2,
    output logic            req_ready,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            div_req,
    output logic            div_signed,
    output logic [XLEN-1:0] div_a,
    output logic [XLEN-1:0] div_b,
    input  logic            div_complete,
    input  logic [XLEN-1:0] div_quot,
    input  logic [XLEN-1:0] div_rem
);

    hilo_state_t     state_q;
    hilo_state_t     state_d;
    hilo_op_t        op_q;
    logic [XLEN-1:0] src1_q;
    logic [XLEN-1:0] src2_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] hi_d;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] lo_d;
    logic            w_issue;

    assign req_ready = resetn & (state_q == ST_IDLE) & ~flush;
    assign w_issue   = req_valid & req_ready;

`ifdef HILO_MUL_EN
    logic [DLEN-1:0] w_prod;

    hilo_mul u_mul (
        .a_i      (src1_q),
        .b_i      (src2_q),
        .signed_i (op_q == OP_MULT),
        .prod_o   (w_prod)
    );
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand and HI/LO registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            op_q   <= OP_NOP;
            src1_q <= '0;
            src2_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            if (w_issue) begin
                op_q   <= req_op;
                src1_q <= req_src1;
                src2_q <= req_src2;
            end
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_issue) begin
                    if (op_is_div(req_op)) begin
                        state_d = ST_DIV_RUN;
                    end else if (op_is_mul(req_op)) begin
                        state_d = ST_MUL_RUN;
                    end
                end
            end
            ST_DIV_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (div_complete) begin
                    state_d = ST_DONE;
                end
            end
            ST_MUL_RUN: begin
                state_d = flush ? ST_IDLE : ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs and HI/LO update
    always_comb begin
        busy    = (state_q != ST_IDLE);
        done    = (state_q == ST_DONE);
        div_req = (state_q == ST_DIV_RUN);
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (w_issue && (req_op == OP_MTHI)) begin
                    hi_d = req_src1;
                end
                if (w_issue && (req_op == OP_MTLO)) begin
                    lo_d = req_src1;
                end
            end
            ST_DIV_RUN: begin
                // A flush coinciding with completion discards the result.
                if (div_complete && !flush) begin
                    hi_d = div_rem;
                    lo_d = div_quot;
                end
            end
            ST_MUL_RUN: begin
`ifdef HILO_MUL_EN
                if (!flush) begin
                    hi_d = w_prod[DLEN-1:XLEN];
                    lo_d = w_prod[XLEN-1:0];
                end
`endif
            end
            default: begin
            end
        endcase
    end

    // Operands stay registered for the whole run, so the divider sees stable inputs.
    assign div_signed = (op_q == OP_DIV);
    assign div_a      = src1_q;
    assign div_b      = src2_q;
    assign hi         = hi_q;
    assign lo         = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_unit
// Brief    : Self-checking bench for hilo_unit with a behavioural divider.
// Revision : 1.0
// ============================================================================
module tb_hilo_unit;
    import hilo_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_src1 = '0;
    logic [31:0] req_src2 = '0;
    logic        flush = 1'b0;
    logic        req_ready;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_req;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_complete = 1'b0;
    logic [31:0] div_quot = '0;
    logic [31:0] div_rem = '0;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;
    int          force_lat = 0;
    int          dv_cnt = 0;
    int          dv_lat = 2;
    logic        dv_fired = 1'b0;

    hilo_unit dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_src1     (req_src1),
        .req_src2     (req_src2),
        .req_ready    (req_ready),
        .flush        (flush),
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo),
        .div_req      (div_req),
        .div_signed   (div_signed),
        .div_a        (div_a),
        .div_b        (div_b),
        .div_complete (div_complete),
        .div_quot     (div_quot),
        .div_rem      (div_rem)
    );

    always #5 clk = ~clk;

    // Returns {remainder, quotient}; C-style truncating division.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        int unsigned ua, ub;
        if (sgn) begin
            sa = a;
            sb = b;
            return {32'(sa % sb), 32'(sa / sb)};
        end
        ua = a;
        ub = b;
        return {32'(ua % ub), 32'(ua / ub)};
    endfunction

    function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            return 64'(sa * sb);
        end
        ua = a;
        ub = b;
        return ua * ub;
    endfunction

    // Divider model: variable latency, garbage outputs outside the completion pulse,
    // needs div_req low for a cycle before it will start again.
    always @(posedge clk) begin
        div_complete <= 1'b0;
        div_quot     <= $urandom;
        div_rem      <= $urandom;
        if (!resetn || !div_req) begin
            dv_cnt   <= 0;
            dv_fired <= 1'b0;
        end else begin
            if (dv_cnt == 0) begin
                dv_lat <= (force_lat != 0) ? force_lat : int'($urandom_range(34, 2));
            end else if (!dv_fired && (dv_cnt == dv_lat - 1)) begin
                div_complete        <= 1'b1;
                {div_rem, div_quot} <= ref_div(div_signed, div_a, div_b);
                dv_fired            <= 1'b1;
            end
            dv_cnt <= dv_cnt + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        #1;
        check("issue_ready", 32'(req_ready), 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        int          k;
        r = ref_div(op == OP_DIV, a, b);
        issue(op, a, b);
        check("div_busy", 32'(busy), 1);
        check("div_req_high", 32'(div_req), 1);
        check("div_a", div_a, a);
        check("div_b", div_b, b);
        check("div_signed", 32'(div_signed), 32'(op == OP_DIV));
        // A stray request while the division runs must not be consumed.
        req_valid = 1'b1;
        req_op    = OP_MTHI;
        req_src1  = 32'hDEAD_0000 ^ a;
        #1;
        k = 1;
        while (!done && k < 40) begin
            check("div_run_not_ready", 32'(req_ready), 0);
            tick();
            k++;
        end
        req_valid = 1'b0;
        check("div_done_seen", 32'(done), 1);
        check("div_latency_in_range", 32'((k >= 4) && (k <= 36)), 1);
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        check("div_hi", hi, exp_hi);
        check("div_lo", lo, exp_lo);
        check("div_req_low_in_done", 32'(div_req), 0);
        tick();
        check("div_done_one_cycle", 32'(done), 0);
        check("div_idle", 32'(busy), 0);
        check("div_ready_after", 32'(req_ready), 1);
    endtask

    task automatic run_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        issue(op, a, b);
        check("mul_busy", 32'(busy), 1);
        check("mul_no_early_done", 32'(done), 0);
        tick();
        check("mul_done_t2", 32'(done), 1);
`ifdef HILO_MUL_EN
        p      = ref_mul(op == OP_MULT, a, b);
        exp_hi = p[63:32];
        exp_lo = p[31:0];
`endif
        check("mul_hi", hi, exp_hi);
        check("mul_lo", lo, exp_lo);
        tick();
        check("mul_done_one_cycle", 32'(done), 0);
        check("mul_ready_t3", 32'(req_ready), 1);
    endtask

    task automatic run_mt(input logic [2:0] op, input logic [31:0] a);
        issue(op, a, $urandom);
        if (op == OP_MTHI) exp_hi = a;
        else exp_lo = a;
        check("mt_not_busy", 32'(busy), 0);
        check("mt_no_done", 32'(done), 0);
        check("mt_hi", hi, exp_hi);
        check("mt_lo", lo, exp_lo);
    endtask

    task automatic run_nop(input logic [2:0] op);
        issue(op, $urandom, $urandom);
        check("nop_not_busy", 32'(busy), 0);
        check("nop_hi", hi, exp_hi);
        check("nop_lo", lo, exp_lo);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int          k;

        // Reset
        resetn = 1'b0;
        repeat (2) tick();
        check("rst_ready_low", 32'(req_ready), 0);
        resetn = 1'b1;
        #1;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_div_req", 32'(div_req), 0);
        check("rst_div_signed", 32'(div_signed), 0);
        check("rst_div_a", div_a, 0);
        check("rst_ready_after", 32'(req_ready), 1);

        // Directed divides
        run_div(OP_DIV, 32'd100, 32'd7);
        run_div(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_div(OP_DIVU, 32'hFFFF_FFF9, 32'd2);

        // Flush five cycles into a long division
        force_lat = 34;
        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (4) tick();
        flush = 1'b1;
        #1;
        check("fl_ready_low", 32'(req_ready), 0);
        tick();
        flush = 1'b0;
        check("fl_idle", 32'(busy), 0);
        check("fl_div_req_low", 32'(div_req), 0);
        check("fl_hi", hi, exp_hi);
        check("fl_lo", lo, exp_lo);
        repeat (3) begin
            tick();
            check("fl_no_done", 32'(done), 0);
        end
        force_lat = 0;
        run_div(OP_DIVU, 32'd10, 32'd3);

        // Flush in the same cycle as completion
        force_lat = 3;
        issue(OP_DIVU, 32'd77, 32'd5);
        k = 0;
        while (!div_complete && k < 40) begin
            tick();
            k++;
        end
        check("cf_complete_seen", 32'(div_complete), 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("cf_idle", 32'(busy), 0);
        check("cf_no_done", 32'(done), 0);
        check("cf_hi", hi, exp_hi);
        check("cf_lo", lo, exp_lo);
        tick();
        check("cf_no_done_later", 32'(done), 0);
        force_lat = 0;

        // Multiplies
        run_mul(OP_MULT, 32'hFFFF_FFFF, 32'd2);
        run_mul(OP_MULTU, 32'hFFFF_FFFF, 32'd2);

        // Back-to-back MTHI / MTLO
        run_mt(OP_MTHI, 32'h0000_1234);
        run_mt(OP_MTLO, 32'h0000_5678);

        // Flush with a request in IDLE
        req_valid = 1'b1;
        req_op    = OP_MTHI;
        req_src1  = 32'hBAD0_BAD0;
        flush     = 1'b1;
        #1;
        check("fi_ready_low", 32'(req_ready), 0);
        tick();
        req_valid = 1'b0;
        flush     = 1'b0;
        check("fi_idle", 32'(busy), 0);
        check("fi_hi", hi, exp_hi);

        // Randomized mix
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(7, 0));
            a  = $urandom;
            b  = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(9, 1)) : 32'($urandom);
            if (b == 0) b = 32'd1;
            if (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            case (op)
                OP_DIV, OP_DIVU:   run_div(op, a, b);
                OP_MULT, OP_MULTU: run_mul(op, a, b);
                OP_MTHI, OP_MTLO:  run_mt(op, a);
                default:           run_nop(op);
            endcase
        end

        // Reset in the middle of a division
        force_lat = 30;
        issue(OP_DIV, 32'd500, 32'd7);
        repeat (2) tick();
        resetn = 1'b0;
        #1;
        check("mr_ready_in_reset", 32'(req_ready), 0);
        tick();
        resetn = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        check("mr_idle", 32'(busy), 0);
        check("mr_div_req", 32'(div_req), 0);
        check("mr_hi", hi, exp_hi);
        check("mr_lo", lo, exp_lo);
        check("mr_done", 32'(done), 0);
        tick();
        check("mr_ready", 32'(req_ready), 1);
        force_lat = 0;
        run_div(OP_DIVU, 32'd10, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
